// File: rtl/store_fu_pkg.sv
// rtl/store_fu_pkg.sv - shared store/speculation widths and level remap helpers
package store_fu_pkg;

    localparam int SPEC_DEPTH     = 4;
    localparam int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1;
    localparam int INST_ID_BIT    = 8;
    localparam int ADDR_BIT       = 16;
    localparam int DATA_BIT       = 16;
    localparam int OFFSET_BIT     = 8;
    localparam int NXT_LEVELS_BIT = SPEC_LEVEL_BIT * (SPEC_DEPTH + 1);

    typedef logic [SPEC_LEVEL_BIT-1:0] spec_level_t;

    // Levels outside 0..SPEC_DEPTH have no field and pass through unchanged.
    function automatic spec_level_t remap_level(input logic [NXT_LEVELS_BIT-1:0] nxt_levels,
                                                input spec_level_t level);
        spec_level_t r;
        r = level;
        for (int i = 0; i <= SPEC_DEPTH; i++) begin
            if (level == spec_level_t'(i)) begin
                r = nxt_levels[i*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT];
            end
        end
        return r;
    endfunction

    function automatic logic is_killed(input logic mispredict, input spec_level_t fail_level,
                                       input spec_level_t level);
        return mispredict && (level != '0) && (level >= fail_level);
    endfunction

endpackage

// File: rtl/store_fu_stage.sv
// rtl/store_fu_stage.sv - one pipeline stage: valid + payload + level with kill/remap
module store_fu_stage
    import store_fu_pkg::*;
#(
    parameter int PAYLOAD_BIT = 40
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      d_vld,
    input  logic [PAYLOAD_BIT-1:0]    d_payload,
    input  spec_level_t               d_level,
    input  logic                      mispredict,
    input  logic                      remap,
    input  spec_level_t               fail_level,
    input  logic [NXT_LEVELS_BIT-1:0] nxt_levels,
    output logic                      q_vld,
    output logic [PAYLOAD_BIT-1:0]    q_payload,
    output spec_level_t               q_level
);

    logic kill_d;
    logic kill_q;

    assign kill_d = is_killed(mispredict, fail_level, d_level);
    assign kill_q = is_killed(mispredict, fail_level, q_level);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_vld <= 1'b0;
        end else if (load) begin
            q_vld <= d_vld && !kill_d;
        end else if (kill_q) begin
            q_vld <= 1'b0;
        end
    end

    // Payload carries no reset; q_vld alone qualifies it.
    always_ff @(posedge clk) begin
        if (load) begin
            q_payload <= d_payload;
            q_level   <= remap ? remap_level(nxt_levels, d_level) : d_level;
        end else if (remap) begin
            q_level   <= remap_level(nxt_levels, q_level);
        end
    end

endmodule

// File: rtl/store_fu.sv
// rtl/store_fu.sv - two-stage store address-generation unit with branch kill/remap
module store_fu
    import store_fu_pkg::*;
#(
    parameter int INST_ID_BIT    = store_fu_pkg::INST_ID_BIT,
    parameter int ADDR_BIT       = store_fu_pkg::ADDR_BIT,
    parameter int DATA_BIT       = store_fu_pkg::DATA_BIT,
    parameter int OFFSET_BIT     = store_fu_pkg::OFFSET_BIT,
    parameter int SPEC_DEPTH     = store_fu_pkg::SPEC_DEPTH,
    parameter int SPEC_LEVEL_BIT = $clog2(SPEC_DEPTH) + 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_vld,
    output logic                                     in_rdy,
    input  logic [INST_ID_BIT-1:0]                   in_id,
    input  logic [ADDR_BIT-1:0]                      in_base,
    input  logic [OFFSET_BIT-1:0]                    in_offset,
    input  logic [DATA_BIT-1:0]                      in_data,
    input  logic [SPEC_LEVEL_BIT-1:0]                in_spec_level,
    output logic                                     out_vld,
    input  logic                                     out_rdy,
    output logic [INST_ID_BIT-1:0]                   out_id,
    output logic [ADDR_BIT-1:0]                      out_addr,
    output logic [DATA_BIT-1:0]                      out_data,
    output logic [SPEC_LEVEL_BIT-1:0]                out_spec_level,
    input  logic                                     br_pred_vld,
    input  logic                                     br_pred_succ,
    input  logic [SPEC_LEVEL_BIT-1:0]                br_pred_fail_level,
    input  logic [SPEC_LEVEL_BIT*(SPEC_DEPTH+1)-1:0] br_pred_succ_nxt_levels,
    output logic                                     busy
);

    localparam int PAYLOAD_BIT = INST_ID_BIT + ADDR_BIT + DATA_BIT;
    localparam int EXT_BIT     = ADDR_BIT - OFFSET_BIT;

    logic                   mispredict;
    logic                   remap;
    logic [ADDR_BIT-1:0]    s1_addr_gen;
    logic                   s1_vld;
    logic                   s2_vld;
    logic [PAYLOAD_BIT-1:0] s1_payload;
    logic [PAYLOAD_BIT-1:0] s2_payload;
    spec_level_t            s1_level;
    spec_level_t            s2_level;
    logic                   s2_load;
    logic                   out_fire;

    assign mispredict  = br_pred_vld && !br_pred_succ;
    assign remap       = br_pred_vld && br_pred_succ;
    assign s1_addr_gen = in_base + {{EXT_BIT{in_offset[OFFSET_BIT-1]}}, in_offset};

    // A killed S2 entry is hidden here so the store buffer never sees it.
    assign out_vld  = s2_vld && !is_killed(mispredict, br_pred_fail_level, s2_level);
    assign out_fire = out_vld && out_rdy;
    assign s2_load  = !s2_vld || out_fire;
    assign in_rdy   = !s1_vld || s2_load;
    assign busy     = s1_vld || s2_vld;

    assign {out_id, out_addr, out_data} = s2_payload;
    assign out_spec_level = remap ? remap_level(br_pred_succ_nxt_levels, s2_level) : s2_level;

    store_fu_stage #(.PAYLOAD_BIT(PAYLOAD_BIT)) u_s1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (in_rdy),
        .d_vld      (in_vld),
        .d_payload  ({in_id, s1_addr_gen, in_data}),
        .d_level    (in_spec_level),
        .mispredict (mispredict),
        .remap      (remap),
        .fail_level (br_pred_fail_level),
        .nxt_levels (br_pred_succ_nxt_levels),
        .q_vld      (s1_vld),
        .q_payload  (s1_payload),
        .q_level    (s1_level)
    );

    store_fu_stage #(.PAYLOAD_BIT(PAYLOAD_BIT)) u_s2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (s2_load),
        .d_vld      (s1_vld),
        .d_payload  (s1_payload),
        .d_level    (s1_level),
        .mispredict (mispredict),
        .remap      (remap),
        .fail_level (br_pred_fail_level),
        .nxt_levels (br_pred_succ_nxt_levels),
        .q_vld      (s2_vld),
        .q_payload  (s2_payload),
        .q_level    (s2_level)
    );

endmodule

// File: tb/tb_store_fu.sv
// tb/tb_store_fu.sv - directed and randomized bench for store_fu
module tb_store_fu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld;
    logic        in_rdy;
    logic [7:0]  in_id;
    logic [15:0] in_base;
    logic [7:0]  in_offset;
    logic [15:0] in_data;
    logic [2:0]  in_spec_level;
    logic        out_vld;
    logic        out_rdy;
    logic [7:0]  out_id;
    logic [15:0] out_addr;
    logic [15:0] out_data;
    logic [2:0]  out_spec_level;
    logic        br_pred_vld;
    logic        br_pred_succ;
    logic [2:0]  br_pred_fail_level;
    logic [14:0] br_pred_succ_nxt_levels;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int nxt_map[5];

    typedef struct {
        int id;
        int addr;
        int data;
        int lvl;
    } ent_t;
    ent_t q[$];

    store_fu dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .in_vld                  (in_vld),
        .in_rdy                  (in_rdy),
        .in_id                   (in_id),
        .in_base                 (in_base),
        .in_offset               (in_offset),
        .in_data                 (in_data),
        .in_spec_level           (in_spec_level),
        .out_vld                 (out_vld),
        .out_rdy                 (out_rdy),
        .out_id                  (out_id),
        .out_addr                (out_addr),
        .out_data                (out_data),
        .out_spec_level          (out_spec_level),
        .br_pred_vld             (br_pred_vld),
        .br_pred_succ            (br_pred_succ),
        .br_pred_fail_level      (br_pred_fail_level),
        .br_pred_succ_nxt_levels (br_pred_succ_nxt_levels),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit killable(input bit mis, input int fail, input int lvl);
        return mis && lvl != 0 && lvl >= fail;
    endfunction

    task automatic set_in(input bit v, input int id, input int base, input int off,
                          input int data, input int lvl);
        in_vld        = v;
        in_id         = 8'(id);
        in_base       = 16'(base);
        in_offset     = 8'(off);
        in_data       = 16'(data);
        in_spec_level = 3'(lvl);
    endtask

    task automatic set_br(input bit v, input bit succ, input int fail);
        br_pred_vld        = v;
        br_pred_succ       = succ;
        br_pred_fail_level = 3'(fail);
        for (int i = 0; i < 5; i++) br_pred_succ_nxt_levels[i*3 +: 3] = 3'(nxt_map[i]);
    endtask

    // Reference: an ordered list of live stores; the unit must emit exactly these, in order.
    task automatic model_step();
        bit mis, rem, fire_in, fire_out;
        int fail, exp_lvl;
        ent_t e;
        mis  = br_pred_vld && !br_pred_succ;
        rem  = br_pred_vld && br_pred_succ;
        fail = int'(br_pred_fail_level);
        chk("busy", 32'(busy), 32'(q.size() != 0));
        if (q.size() == 0) chk("out_vld_idle", 32'(out_vld), 0);
        else if (killable(mis, fail, q[0].lvl)) chk("out_vld_killed", 32'(out_vld), 0);
        if (out_vld && q.size() > 0) begin
            exp_lvl = rem ? nxt_map[q[0].lvl] : q[0].lvl;
            chk("out_id", 32'(out_id), q[0].id);
            chk("out_addr", 32'(out_addr), q[0].addr);
            chk("out_data", 32'(out_data), q[0].data);
            chk("out_level", 32'(out_spec_level), exp_lvl);
        end
        fire_out = out_vld && out_rdy;
        fire_in  = in_vld && in_rdy;
        if (fire_out && q.size() > 0) void'(q.pop_front());
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (killable(mis, fail, q[i].lvl)) q.delete(i);
            else if (rem) q[i].lvl = nxt_map[q[i].lvl];
        end
        if (fire_in && !killable(mis, fail, int'(in_spec_level))) begin
            e.id   = int'(in_id);
            e.addr = (int'(in_base) + int'($signed(in_offset))) & 32'hFFFF;
            e.data = int'(in_data);
            e.lvl  = rem ? nxt_map[int'(in_spec_level)] : int'(in_spec_level);
            q.push_back(e);
        end
    endtask

    task automatic cycle();
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) nxt_map[i] = i;
        rst_n   = 1'b0;
        out_rdy = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        set_br(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_rdy", 32'(in_rdy), 1);
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unstalled latency: accepted at cycle 0, visible at cycle 2.
        set_in(1, 3, 'h1000, 'hFC, 'hBEEF, 0);
        #1 chk("lat_in_rdy", 32'(in_rdy), 1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        #1 chk("lat_c1_out_vld", 32'(out_vld), 0);
        cycle();
        #1;
        chk("lat_c2_out_vld", 32'(out_vld), 1);
        chk("lat_addr", 32'(out_addr), 'h0FFC);
        chk("lat_data", 32'(out_data), 'hBEEF);
        chk("lat_id", 32'(out_id), 3);
        chk("lat_level", 32'(out_spec_level), 0);
        cycle();

        // Address wrap.
        set_in(1, 7, 'hFFFE, 'h05, 'h1234, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        cycle();
        #1 chk("wrap_addr", 32'(out_addr), 'h0003);
        cycle();

        // Backpressure with three back-to-back stores.
        out_rdy = 1'b0;
        set_in(1, 10, 'h2000, 1, 'hA0, 0);
        cycle();
        set_in(1, 11, 'h2000, 2, 'hA1, 0);
        cycle();
        set_in(1, 12, 'h2000, 3, 'hA2, 0);
        #1 chk("bp_in_rdy_0", 32'(in_rdy), 0);
        chk("bp_hold_id_0", 32'(out_id), 10);
        cycle();
        #1 chk("bp_in_rdy_1", 32'(in_rdy), 0);
        chk("bp_hold_id_1", 32'(out_id), 10);
        chk("bp_hold_addr", 32'(out_addr), 'h2001);
        cycle();
        out_rdy = 1'b1;
        #1 chk("bp_release_in_rdy", 32'(in_rdy), 1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        #1 chk("bp_second_id", 32'(out_id), 11);
        cycle();
        #1 chk("bp_third_id", 32'(out_id), 12);
        cycle();
        #1 chk("bp_drained", 32'(busy), 0);
        cycle();

        // Mispredict: S1 level 2 and input level 3 die, S2 level 1 survives.
        set_in(1, 20, 'h3000, 0, 'h20, 1);
        cycle();
        set_in(1, 21, 'h3000, 0, 'h21, 2);
        cycle();
        set_in(1, 22, 'h3000, 0, 'h22, 3);
        set_br(1, 0, 2);
        #1 chk("mp_in_rdy", 32'(in_rdy), 1);
        chk("mp_out_vld", 32'(out_vld), 1);
        chk("mp_out_id", 32'(out_id), 20);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        set_br(0, 0, 0);
        #1 chk("mp_after_busy", 32'(busy), 0);
        cycle();

        // Same-cycle kill of the output register.
        set_in(1, 30, 'h4000, 0, 'h30, 2);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        cycle();
        set_br(1, 0, 1);
        #1 chk("sk_out_vld", 32'(out_vld), 0);
        cycle();
        set_br(0, 0, 0);
        #1 chk("sk_after_busy", 32'(busy), 0);
        cycle();

        // Correct prediction remaps 2->1, 1->0.
        set_in(1, 40, 'h5000, 0, 'h40, 1);
        cycle();
        set_in(1, 41, 'h5000, 0, 'h41, 2);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        nxt_map = '{0, 0, 1, 2, 3};
        set_br(1, 1, 0);
        #1 chk("cp_out_vld", 32'(out_vld), 1);
        chk("cp_out_level", 32'(out_spec_level), 0);
        cycle();
        set_br(0, 0, 0);
        #1 chk("cp_next_id", 32'(out_id), 41);
        chk("cp_next_level", 32'(out_spec_level), 1);
        cycle();

        // Reset in flight, then restart from idle.
        set_in(1, 50, 'h6000, 0, 'h50, 0);
        cycle();
        set_in(1, 51, 'h6000, 0, 'h51, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_out_vld", 32'(out_vld), 0);
        chk("mid_rst_in_rdy", 32'(in_rdy), 1);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_in(1, 52, 'h7000, 'h80, 'h52, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        cycle();
        #1 chk("post_rst_out_vld", 32'(out_vld), 1);
        chk("post_rst_addr", 32'(out_addr), 'h6F80);
        cycle();

        // Randomized traffic against the reference list.
        for (int n = 0; n < 800; n++) begin
            set_in($urandom_range(0, 9) < 7, $urandom_range(0, 255), $urandom_range(0, 65535),
                   $urandom_range(0, 255), $urandom_range(0, 65535), $urandom_range(0, 4));
            out_rdy = $urandom_range(0, 9) < 6;
            for (int i = 0; i < 5; i++) nxt_map[i] = $urandom_range(0, 4);
            set_br($urandom_range(0, 99) < 20, $urandom_range(0, 1), $urandom_range(0, 4));
            cycle();
        end

        set_in(0, 0, 0, 0, 0, 0);
        set_br(0, 0, 0);
        out_rdy = 1'b1;
        repeat (6) cycle();
        chk("final_queue_empty", 32'(q.size()), 0);
        chk("final_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_fu.md
STORE_FU -- requirements
Module: store_fu

Interface
REQ-001 Parameters: INST_ID_BIT=8 (instruction id width); ADDR_BIT=16 (address width); DATA_BIT=16 (store data width); OFFSET_BIT=8 (signed immediate width); SPEC_DEPTH=4 (max unresolved branches); SPEC_LEVEL_BIT=clog2(SPEC_DEPTH)+1 (speculation level width).
REQ-002 clk  in  1  clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_vld / in_rdy  in / out  1 / 1  issue handshake; transfer when both high.
REQ-005 in_id, in_base, in_offset, in_data  in  INST_ID_BIT, ADDR_BIT, OFFSET_BIT, DATA_BIT  store id, base register value, signed offset, store data.
REQ-006 in_spec_level  in  SPEC_LEVEL_BIT  speculation level; 0 = non-speculative.
REQ-007 out_vld / out_rdy  out / in  1 / 1  handshake toward store buffer.
REQ-008 out_id, out_addr, out_data, out_spec_level  out  INST_ID_BIT, ADDR_BIT, DATA_BIT, SPEC_LEVEL_BIT  completed store.
REQ-009 br_pred_vld, br_pred_succ  in  1, 1  branch resolution strobe; prediction correct.
REQ-010 br_pred_fail_level  in  SPEC_LEVEL_BIT  on mispredict, kill every store with level >= this.
REQ-011 br_pred_succ_nxt_levels  in  SPEC_LEVEL_BIT*(SPEC_DEPTH+1)  on correct prediction, level L becomes field L (field L at bits [L*SPEC_LEVEL_BIT +: SPEC_LEVEL_BIT]).
REQ-012 busy  out  1  any stage valid.

Function
REQ-013 Two-stage pipeline: S1 = address generation, S2 = output register; each stage holds a valid bit, id, addr/base+offset, data, and level.
REQ-014 S1 shall compute addr = in_base + sign-extended in_offset, modulo 2^ADDR_BIT (wrap, no overflow flag); S2 registers the result.
REQ-015 Stage advance: S2 loads from S1 when S2 is empty or the out handshake fires; S1 loads from input when S1 is empty or S1 advances; throughput 1 store/cycle.
REQ-016 in_rdy = !s1_vld || s1 advances this cycle (combinational from out_rdy permitted); no input-to-output combinational data path.
REQ-017 Latency: a store accepted in cycle N shall present out_vld in cycle N+2 when unstalled.
REQ-018 Mispredict (br_pred_vld && !br_pred_succ): every stage with level >= br_pred_fail_level is cleared at the next edge; an input accepted in the same cycle with in_spec_level >= fail level is accepted (in_rdy unaffected) and discarded.
REQ-019 Same-cycle kill: out_vld shall be deasserted combinationally in a mispredict cycle when S2 level >= fail level, so the store buffer never receives a killed store.
REQ-020 Correct prediction (br_pred_vld && br_pred_succ): every valid stage level L becomes nxt_levels[L]; an input accepted that cycle is stored with its remapped level; data moving S1->S2 carries the remapped level.
REQ-021 out_spec_level shall equal nxt_levels[s2_level] in a correct-prediction cycle, otherwise s2_level, because the store buffer writes it without remap.
REQ-022 Stalled S2 (out_vld && !out_rdy) holds all out_* stable, except level remap per REQ-020/021 and kill per REQ-019.
REQ-023 Level-0 stores are never killed.

Reset
REQ-024 rst_n low: s1_vld=0, s2_vld=0, hence out_vld=0, busy=0, in_rdy=1; data registers need no reset; out data values are don't-care while out_vld=0.
REQ-025 Reset asserted mid-operation discards in-flight stores; first accept after deassertion behaves as from idle.

Structure
REQ-026 Shared package: SPEC_DEPTH, SPEC_LEVEL_BIT, INST_ID_BIT, ADDR_BIT, DATA_BIT defaults, and a level-remap function (index nxt_levels by level), reused by store buffer and other FUs.
REQ-027 One sub-module: store_fu_stage (valid + payload register applying kill/remap), instantiated twice.

Verification
REQ-028 Unstalled: store id=3, base=0x1000, offset=-4 (0xFC), data=0xBEEF, level 0, accepted at cycle 0 -> out_vld at cycle 2, addr=0x0FFC, data=0xBEEF, level 0.
REQ-029 Wrap: base=0xFFFE, offset=+5 -> out_addr=0x0003.
REQ-030 Backpressure: 3 back-to-back stores, out_rdy=0 for 4 cycles -> in_rdy low after 2 accepted; outputs stable; all 3 emerge in order once out_rdy=1.
REQ-031 Mispredict fail_level=2 while S1 holds level 2 and S2 holds level 1 and input has level 3 -> only level 1 store emerges; input discarded; in_rdy stays 1.
REQ-032 Same-cycle kill: S2 level 2, out_rdy=1, mispredict fail_level=1 -> out_vld=0 that cycle; no output ever emerges.
REQ-033 Correct prediction with nxt_levels mapping 2->1, 1->0 while S2 level 1 is output -> out_spec_level=0 that cycle; S1 level 2 later emerges with level 1.
